// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared pipeline types and constants for the fetch front end:
//            data width, instruction size, fetch FSM state encoding, default
//            reset PC and small PC arithmetic helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // Sequential successor; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  // Word-align a redirect target by clearing the low byte-offset bits.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Purpose  : Instruction-memory request/ready bus between the fetch
//            sequencer (master) and instruction memory (slave).
// Signals  : imem_req   - request valid (master -> slave)
//            imem_addr  - word-aligned request address (master -> slave)
//            imem_ready - request accepted, rdata valid (slave -> master)
//            imem_rdata - instruction word (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
  import pipeline_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Purpose  : One-entry {pc, instr} buffer that catches a fetch response
//            accepted while the IF slot is stalled.
// Ports    : clk, reset (async, active-high)
//            load, load_pc, load_instr - capture an entry
//            drain                    - entry moved out, mark empty
//            clear                    - flush (redirect), mark empty
//            buf_valid, buf_pc, buf_instr - stored entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            load,
  input  wire logic [XLEN-1:0] load_pc,
  input  wire logic [XLEN-1:0] load_instr,
  input  wire logic            drain,
  input  wire logic            clear,
  output logic                 buf_valid,
  output logic [XLEN-1:0]      buf_pc,
  output logic [XLEN-1:0]      buf_instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    // Clear wins: a flush discards whatever was caught this cycle too.
    if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_pc    = pc_q;
  assign buf_instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch sequencer. Owns the PC, issues single-outstanding
//            requests to instruction memory, presents instructions to decode
//            through a valid/stall slot and applies EX redirects, killing an
//            in-flight request without aborting its handshake.
// Ports    : clk, reset (async, active-high)
//            stall                       - decode cannot accept
//            redirect_valid, redirect_pc - taken branch/jump from EX
//            imem (fetch_ctrl_if.master) - instruction memory bus
//            if_valid, if_pc, if_instr, if_next_pc - IF output slot
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            stall,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  fetch_ctrl_if.master         imem,
  output logic                 if_valid,
  output logic [XLEN-1:0]      if_pc,
  output logic [XLEN-1:0]      if_instr,
  output logic [XLEN-1:0]      if_next_pc
);

  localparam logic [1:0] ST_BOOT = 2'(BOOT);
  localparam logic [1:0] ST_REQ  = 2'(REQ);
  localparam logic [1:0] ST_HOLD = 2'(HOLD);
  localparam logic [1:0] ST_KILL = 2'(KILL);

  logic [1:0]      state_q,      state_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic            imem_req_q,   imem_req_d;
  logic            if_valid_q,   if_valid_d;
  logic [XLEN-1:0] if_pc_q,      if_pc_d;
  logic [XLEN-1:0] if_instr_q,   if_instr_d;
  logic [XLEN-1:0] if_next_pc_q, if_next_pc_d;

  logic            slot_load;
  logic [XLEN-1:0] slot_load_pc;
  logic [XLEN-1:0] slot_load_instr;
  logic            buf_load, buf_drain, buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc, buf_instr;
  logic [XLEN-1:0] target;

  assign target = pc_align(redirect_pc);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .load_pc    (pc_q),
    .load_instr (imem.imem_rdata),
    .drain      (buf_drain),
    .clear      (buf_clear),
    .buf_valid  (buf_valid),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_pc_d    = pending_pc_q;
    if_valid_d      = if_valid_q;
    if_pc_d         = if_pc_q;
    if_instr_d      = if_instr_q;
    if_next_pc_d    = if_next_pc_q;
    slot_load       = 1'b0;
    slot_load_pc    = pc_q;
    slot_load_instr = imem.imem_rdata;
    buf_load        = 1'b0;
    buf_drain       = 1'b0;
    buf_clear       = 1'b0;

    // Decode consumes the slot; a load below overrides this.
    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (redirect_valid) begin
          pc_d = target;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            // Handshake must complete at the old address; remember target.
            pending_pc_d = target;
            state_d      = ST_KILL;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_inc(pc_q);
          if (!if_valid_q || !stall) begin
            slot_load = 1'b1;
          end else begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (!stall) begin
          slot_load       = 1'b1;
          slot_load_pc    = buf_pc;
          slot_load_instr = buf_instr;
          buf_drain       = buf_valid;
          state_d         = ST_REQ;
        end
      end
      ST_KILL: begin
        if (imem.imem_ready) begin
          pc_d    = redirect_valid ? target : pending_pc_q;
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          pending_pc_d = target;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (slot_load) begin
      if_valid_d   = 1'b1;
      if_pc_d      = slot_load_pc;
      if_instr_d   = slot_load_instr;
      if_next_pc_d = pc_inc(slot_load_pc);
    end

    // Flush has priority over any load or hold decided above.
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      buf_clear  = 1'b1;
    end

    imem_req_d = (state_d == ST_REQ) || (state_d == ST_KILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      imem_req_q   <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      if_next_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      imem_req_q   <= imem_req_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_next_pc_q <= if_next_pc_d;
    end
  end

  // pc_q stays at the outstanding address in REQ and KILL, so it doubles as
  // the registered request address.
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;

  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_instr   = if_instr_q;
  assign if_next_pc = if_next_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl: directed vector table plus
//            hand-written sequences for wrap, KILL overwrite and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready_r = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, if_next_pc;

  int checks = 0;
  int errors = 0;

  fetch_ctrl_if imem_bus ();

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign imem_bus.imem_ready = ready_r;
  assign imem_bus.imem_rdata = instr_of(imem_bus.imem_addr);

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_next_pc     (if_next_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic rdy, input logic ereq, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ready = rdy;
    v.exp_req = ereq; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic ev, input logic [31:0] ep);
    chk({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, ev});
    if (ev) begin
      chk({tag, " if_pc"},      if_pc,      ep);
      chk({tag, " if_instr"},   if_instr,   instr_of(ep));
      chk({tag, " if_next_pc"}, if_next_pc, ep + 32'd4);
    end
  endtask

  task automatic chk_bus(input string tag, input logic er, input logic [31:0] ea);
    chk({tag, " imem_req"},  {31'b0, imem_bus.imem_req}, {31'b0, er});
    chk({tag, " imem_addr"}, imem_bus.imem_addr, ea);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    stall = s; redirect_valid = r; redirect_pc = rp; ready_r = rdy;
  endtask

  initial begin
    // stall, redir, rpc, ready | req, addr, valid, pc
    vecs[0]  = mk(0, 0, 32'h0,   1, 0, 32'h100, 0, 32'h0);    // BOOT
    vecs[1]  = mk(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);    // first request
    vecs[2]  = mk(0, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100);  // valid in cycle 2
    vecs[3]  = mk(1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h104);  // accept while stalled
    vecs[4]  = mk(1, 0, 32'h0,   1, 0, 32'h10C, 1, 32'h104);  // HOLD
    vecs[5]  = mk(1, 0, 32'h0,   1, 0, 32'h10C, 1, 32'h104);
    vecs[6]  = mk(0, 0, 32'h0,   0, 0, 32'h10C, 1, 32'h104);  // release
    vecs[7]  = mk(0, 0, 32'h0,   0, 1, 32'h10C, 1, 32'h108);  // buffered instr
    vecs[8]  = mk(0, 1, 32'h200, 0, 1, 32'h10C, 0, 32'h0);    // redirect while waiting
    vecs[9]  = mk(0, 0, 32'h0,   0, 1, 32'h10C, 0, 32'h0);    // KILL holds old addr
    vecs[10] = mk(0, 0, 32'h0,   1, 1, 32'h10C, 0, 32'h0);    // killed response
    vecs[11] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
    vecs[12] = mk(1, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200);  // into HOLD
    vecs[13] = mk(1, 1, 32'h203, 1, 0, 32'h208, 1, 32'h200);  // redirect in HOLD
    vecs[14] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200);
    vecs[16] = mk(1, 1, 32'h303, 1, 1, 32'h208, 1, 32'h204);  // redirect + stall + ready
    vecs[17] = mk(0, 0, 32'h0,   1, 1, 32'h300, 0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,   0, 1, 32'h304, 1, 32'h300);
    vecs[19] = mk(0, 0, 32'h0,   0, 1, 32'h304, 0, 32'h0);    // 3 wait cycles
    vecs[20] = mk(0, 0, 32'h0,   0, 1, 32'h304, 0, 32'h0);
    vecs[21] = mk(0, 0, 32'h0,   1, 1, 32'h304, 0, 32'h0);
    vecs[22] = mk(0, 0, 32'h0,   0, 1, 32'h308, 1, 32'h304);
    vecs[23] = mk(0, 0, 32'h0,   0, 1, 32'h308, 0, 32'h0);
    vecs[24] = mk(0, 0, 32'h0,   0, 1, 32'h308, 0, 32'h0);
    vecs[25] = mk(0, 0, 32'h0,   1, 1, 32'h308, 0, 32'h0);
    vecs[26] = mk(0, 0, 32'h0,   0, 1, 32'h30C, 1, 32'h308);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bus("reset", 1'b0, 32'h100);
    chk("reset if_valid",   {31'b0, if_valid}, 32'h0);
    chk("reset if_pc",      if_pc,      32'h0);
    chk("reset if_instr",   if_instr,   32'h0);
    chk("reset if_next_pc", if_next_pc, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      chk_bus($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
      chk_slot($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d no_10C", i), {31'b0, (if_pc == 32'h10C)}, 32'h0);
      end
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      @(negedge clk);
    end

    // PC wrap: misaligned target near the top of the address space.
    drive(0, 1, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    chk_bus("wrap req", 1'b1, 32'hFFFF_FFFC);
    chk_slot("wrap flush", 1'b0, 32'h0);
    drive(0, 0, 32'h0, 1);
    @(negedge clk);
    chk_bus("wrap next", 1'b1, 32'h0000_0000);
    chk_slot("wrap slot", 1'b1, 32'hFFFF_FFFC);

    // Latest redirect wins during KILL.
    drive(0, 1, 32'h400, 0);
    @(negedge clk);
    chk_bus("kill1", 1'b1, 32'h0);
    chk_slot("kill1", 1'b0, 32'h0);
    drive(0, 1, 32'h500, 0);
    @(negedge clk);
    chk_bus("kill2", 1'b1, 32'h0);
    drive(0, 0, 32'h0, 1);
    @(negedge clk);
    chk_bus("kill done", 1'b1, 32'h500);
    chk_slot("kill done", 1'b0, 32'h0);
    drive(0, 0, 32'h0, 1);
    @(negedge clk);
    chk_slot("kill target", 1'b1, 32'h500);
    drive(0, 0, 32'h0, 0);
    @(negedge clk);
    chk_bus("prewait", 1'b1, 32'h504);

    // Asynchronous reset mid-wait, between clock edges.
    #2 reset = 1'b1;
    #1;
    chk_bus("async reset", 1'b0, 32'h100);
    chk("async if_valid", {31'b0, if_valid}, 32'h0);
    chk("async if_pc",    if_pc, 32'h0);
    chk("async if_instr", if_instr, 32'h0);
    ready_r = 1'b1;  // stale response arriving while in reset
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_bus("post boot", 1'b0, 32'h100);
    chk_slot("post boot", 1'b0, 32'h0);
    @(negedge clk);
    chk_bus("post req", 1'b1, 32'h100);
    chk_slot("post req", 1'b0, 32'h0);
    @(negedge clk);
    chk_bus("post next", 1'b1, 32'h104);
    chk_slot("post slot", 1'b1, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer in front of the IF stage. It owns the program counter and drives a single-outstanding request/ready handshake to instruction memory. It presents fetched instructions to decode through a valid/stall interface and applies branch/jump redirects from EX, including discarding an in-flight response. It replaces free-running pc+4 sequencing and supports multi-cycle memories and pipeline stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  decode cannot accept; the IF output slot holds.
- redirect_valid  in  1  taken branch/jump from EX; flushes IF.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address, word aligned.
- imem_ready  in  1  memory accepts the request; imem_rdata valid the same cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  IF output slot holds a valid instruction.
- if_pc  out  32  PC of the slot instruction.
- if_instr  out  32  slot instruction.
- if_next_pc  out  32  if_pc + 4.

## Operation
- States: BOOT, REQ, HOLD, KILL.
- BOOT: imem_req=0. Unconditionally go to REQ on the next cycle.
- REQ: imem_req=1, imem_addr=pc.
  - If imem_ready and the slot is free (!if_valid or !stall): load the slot with {pc, rdata, pc+4}, set if_valid=1, set pc←pc+4, stay in REQ. With zero-wait memory this gives back-to-back issue.
  - If imem_ready and the slot is blocked (if_valid and stall): capture rdata and pc in a one-entry buffer, set pc←pc+4, go to HOLD.
  - If !imem_ready: hold imem_addr stable.
- Slot consumption: decode consumes the slot when if_valid and !stall. If no load occurs in a consuming cycle, if_valid←0.
- HOLD: imem_req=0. When !stall, move the buffer into the slot and go to REQ.
- Redirect has the highest priority over stall, ready and HOLD. In the cycle after redirect_valid, if_valid=0 and the buffer is discarded.
  - From REQ with !imem_ready, go to KILL and store the target in pending_pc. The request stays asserted at the old address; the handshake is never aborted.
  - From REQ with imem_ready: discard rdata, set pc←target, stay in REQ.
  - From HOLD or BOOT: set pc←target and go to REQ.
- KILL: imem_req=1 at the old address. On imem_ready, discard rdata, set pc←pending_pc, go to REQ. A further redirect during KILL overwrites pending_pc (latest wins).
- Arithmetic: all PC math is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Reset (asynchronous, any state, mid-handshake included):
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0, if_next_pc=0, buffer cleared.
  - A memory response arriving after reset is ignored.

## Timing
- Cycle 0 after reset release is BOOT. Cycle 1 is the first request at RESET_PC. With zero-wait memory, if_valid=1 in cycle 2.
- Fetch latency: one cycle after the accepting imem_ready edge. Throughput is 1 instruction/cycle with zero-wait memory.
- Redirect in cycle N:
  - If REQ was accepted or the state was HOLD: if_valid=0 in N+1, imem_addr=target in N+1, target instruction valid in N+2 (zero wait).
  - If KILL was entered: the target is requested in the cycle after the killed response.
- Slot outputs change only on a load, a consumption or a flush. They are stable throughout a stall.
- imem_req and imem_addr are registered outputs.

## Structure
- Shared package pipeline_pkg: XLEN=32, INSTR_BYTES=4, fetch_state_t enum {BOOT, REQ, HOLD, KILL}, and the RESET_PC default constant.
- One sub-module: fetch_skid_buf, a one-entry {pc, instr} buffer with load, drain and clear.
- Everything else lives in fetch_ctrl.

## Test plan
- Zero-wait memory (ready tied to 1), RESET_PC=0x100 → imem_addr sequence 0x100, 0x104, 0x108; if_valid rises in cycle 2; if_next_pc=if_pc+4.
- Ready delayed 3 cycles per request → imem_addr stable through the wait; one instruction per 4 cycles; no duplicate or skipped PC.
- stall held 3 cycles while a response is accepted → enters HOLD; the slot is unchanged during the stall; on release the buffered instruction (pc 0x108) appears next, then the fetch at 0x10C.
- redirect_valid with target 0x200 while a request to 0x10C waits → enters KILL; the 0x10C response is discarded; the next request is 0x200; if_pc never shows 0x10C.
- Redirect to 0x203 during stall and HOLD → flush wins; if_valid=0 next cycle; the next fetch is at 0x200.
- PC=0xFFFF_FFFC fetch → next request 0x0000_0000. Asynchronous reset asserted mid-wait → outputs at reset values immediately; the first post-reset request is at RESET_PC.
